vector_rf_write_arbiter: RTL and testbench

- Sequences all write-backs into the 32-entry vector register file and shares its single write port between two producers: the vector ALU and the vector load/store unit (LSU).
- Keeps a 32-bit busy scoreboard of vector destinations reserved by decode, so decode can stall on RAW/WAW hazards against in-flight writes.
- Sits between the execute-stage producers and the vector register file. It drives the register file's rf_signal, rd, data, length and write_back_enabled inputs, and consumes its rf_status output.

---
 rtl/vector_rf_write_arbiter.sv | 125 ++++++++++++
 tb/tb_vector_rf_write_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_rf_write_arbiter.sv
// Write-back arbiter for the vector register file: ALU and LSU share one write port, plus a 32-entry busy scoreboard.
// Optional macro VRF_ARB_FIXED_PRIO_EN: LSU always wins a tie instead of round-robin.
`ifndef VECTOR_RF_NOP
`define VECTOR_RF_NOP 2'b00
`endif
`ifndef VECTOR_RF_WRITE
`define VECTOR_RF_WRITE 2'b01
`endif
`ifndef RF_NOP
`define RF_NOP 2'b00
`endif
`ifndef RF_FINISHED
`define RF_FINISHED 2'b01
`endif

module vector_rf_write_arbiter #(
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy_in,
    input  logic                          alu_req,
    input  logic [4:0]                    alu_rd,
    input  logic [VECTOR_SIZE*LEN-1:0]    alu_data,
    input  logic [ENTRY_INDEX_SIZE-1:0]   alu_length,
    output logic                          alu_ack,
    input  logic                          lsu_req,
    input  logic [4:0]                    lsu_rd,
    input  logic [VECTOR_SIZE*LEN-1:0]    lsu_data,
    input  logic [ENTRY_INDEX_SIZE-1:0]   lsu_length,
    output logic                          lsu_ack,
    input  logic                          rsv_valid,
    input  logic [4:0]                    rsv_rd,
    input  logic [4:0]                    chk_rs1,
    input  logic [4:0]                    chk_rs2,
    input  logic [4:0]                    chk_rd,
    output logic                          hazard,
    output logic [31:0]                   busy_mask,
    output logic [1:0]                    rf_signal,
    output logic [4:0]                    rf_rd,
    output logic [VECTOR_SIZE*LEN-1:0]    rf_data,
    output logic [ENTRY_INDEX_SIZE-1:0]   rf_length,
    output logic                          write_back_enabled,
    input  logic [1:0]                    rf_status
);

    typedef enum logic [1:0] {IDLE, WRITE, WAIT} state_t;

    state_t      state;
    logic        winner_lsu;
    logic        pick_lsu;
    logic        done;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
`ifndef VRF_ARB_FIXED_PRIO_EN
    logic        last_grant_lsu;
`endif

    always_comb begin
`ifdef VRF_ARB_FIXED_PRIO_EN
        pick_lsu = lsu_req;
`else
        pick_lsu = lsu_req && (!alu_req || !last_grant_lsu);
`endif
    end

    // NOTE: the ack is combinational so the producer sees it in the same cycle the
    // register file reports completion; gating with rst keeps an abandoned write silent.
    assign done    = (state == WAIT) && (rf_status == `RF_FINISHED) && rdy_in && !rst;
    assign alu_ack = done && !winner_lsu;
    assign lsu_ack = done && winner_lsu;

    assign set_mask = rsv_valid ? (32'd1 << rsv_rd) : 32'd0;
    assign clr_mask = done      ? (32'd1 << rf_rd)  : 32'd0;
    assign hazard   = busy_mask[chk_rs1] | busy_mask[chk_rs2] | busy_mask[chk_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            busy_mask          <= '0;
            winner_lsu         <= 1'b0;
            rf_rd              <= '0;
            rf_data            <= '0;
            rf_length          <= '0;
            write_back_enabled <= 1'b0;
            rf_signal          <= `VECTOR_RF_NOP;
`ifndef VRF_ARB_FIXED_PRIO_EN
            last_grant_lsu     <= 1'b1;
`endif
        end else if (rdy_in) begin
            // NOTE: the set is OR-ed in after the clear, so a same-cycle reservation wins.
            busy_mask <= (busy_mask & ~clr_mask) | set_mask;
            unique case (state)
                IDLE: begin
                    if (alu_req || lsu_req) begin
                        winner_lsu         <= pick_lsu;
                        rf_rd              <= pick_lsu ? lsu_rd     : alu_rd;
                        rf_data            <= pick_lsu ? lsu_data   : alu_data;
                        rf_length          <= pick_lsu ? lsu_length : alu_length;
                        write_back_enabled <= 1'b1;
                        rf_signal          <= `VECTOR_RF_WRITE;
                        state              <= WRITE;
                    end
                end
                WRITE: begin
                    write_back_enabled <= 1'b0;
                    rf_signal          <= `VECTOR_RF_NOP;
                    state              <= WAIT;
                end
                WAIT: begin
                    if (done) begin
`ifndef VRF_ARB_FIXED_PRIO_EN
                        last_grant_lsu <= winner_lsu;
`endif
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_rf_write_arbiter.sv
// Self-checking bench for vector_rf_write_arbiter: scoreboard vector table, directed
// handshake sequences, then randomized traffic against a transaction-level model.
`ifndef VECTOR_RF_NOP
`define VECTOR_RF_NOP 2'b00
`endif
`ifndef VECTOR_RF_WRITE
`define VECTOR_RF_WRITE 2'b01
`endif
`ifndef RF_NOP
`define RF_NOP 2'b00
`endif
`ifndef RF_FINISHED
`define RF_FINISHED 2'b01
`endif

module tb_vector_rf_write_arbiter;

    localparam int W = 256;

    logic clk = 1'b0;
    logic rst, rdy_in, alu_req, lsu_req, rsv_valid;
    logic [4:0] alu_rd, lsu_rd, rsv_rd, chk_rs1, chk_rs2, chk_rd, rf_rd;
    logic [W-1:0] alu_data, lsu_data, rf_data;
    logic [2:0] alu_length, lsu_length, rf_length;
    logic alu_ack, lsu_ack, hazard, write_back_enabled;
    logic [31:0] busy_mask;
    logic [1:0] rf_signal, rf_status;

    int checks = 0;
    int errors = 0;

    vector_rf_write_arbiter dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .alu_req(alu_req), .alu_rd(alu_rd), .alu_data(alu_data), .alu_length(alu_length), .alu_ack(alu_ack),
        .lsu_req(lsu_req), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_length(lsu_length), .lsu_ack(lsu_ack),
        .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .hazard(hazard), .busy_mask(busy_mask),
        .rf_signal(rf_signal), .rf_rd(rf_rd), .rf_data(rf_data), .rf_length(rf_length),
        .write_back_enabled(write_back_enabled), .rf_status(rf_status)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rdy_in = 1'b1; alu_req = 1'b0; lsu_req = 1'b0; rsv_valid = 1'b0;
        alu_rd = '0; lsu_rd = '0; rsv_rd = '0; chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
        alu_data = '0; lsu_data = '0; alu_length = '0; lsu_length = '0;
        rf_status = `RF_NOP;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    function automatic logic [W-1:0] rand_vec();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Waits (bounded) for the selected ack; returns with the ack cycle current.
    task automatic wait_ack(input bit want_lsu, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (want_lsu ? lsu_ack : alu_ack) seen = 1'b1;
            else tick();
        end
        check({name, "_ack_seen"}, seen, 1'b1);
    endtask

    typedef struct {
        bit          rsv_valid;
        logic [4:0]  rsv_rd;
        logic [4:0]  c1, c2, c3;
        bit          exp_hz;
        logic [31:0] exp_busy;
    } sb_vec_t;

    sb_vec_t tbl[8];

    // Transaction-level model state for the random phase.
    bit          m_busy[32];
    bit          m_active, m_owner_lsu, m_last_lsu;
    int          m_age;
    logic [4:0]  m_rd;
    logic [2:0]  m_len;
    logic [W-1:0] m_data;

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_active = 1'b0; m_owner_lsu = 1'b0; m_last_lsu = 1'b1; m_age = 0;
        m_rd = '0; m_len = '0; m_data = '0;
    endtask

    initial begin
        int a_cyc, l_cyc;
        bit pa, pl, apend, lpend, ea_prev, el_prev, exp_ack, exp_wbe, exp_hz, win_lsu;
        logic [31:0] exp_mask;

        rst = 1'b1;
        idle_inputs();
        do_reset();

        // Reset state
        check("rst_busy", busy_mask, 0);
        check("rst_wbe", write_back_enabled, 0);
        check("rst_signal", rf_signal, `VECTOR_RF_NOP);
        check("rst_rd", rf_rd, 0);
        check("rst_len", rf_length, 0);
        check("rst_data", rf_data, 0);
        check("rst_acks", {alu_ack, lsu_ack}, 0);

        // Scoreboard vector table
        tbl[0] = '{1'b1, 5'd7,  5'd0,  5'd7, 5'd0,  1'b0, 32'h0000_0080};
        tbl[1] = '{1'b0, 5'd0,  5'd0,  5'd7, 5'd0,  1'b1, 32'h0000_0080};
        tbl[2] = '{1'b1, 5'd0,  5'd7,  5'd1, 5'd2,  1'b1, 32'h0000_0081};
        tbl[3] = '{1'b0, 5'd0,  5'd0,  5'd0, 5'd0,  1'b1, 32'h0000_0081};
        tbl[4] = '{1'b1, 5'd7,  5'd3,  5'd4, 5'd5,  1'b0, 32'h0000_0081};
        tbl[5] = '{1'b1, 5'd31, 5'd31, 5'd1, 5'd2,  1'b0, 32'h8000_0081};
        tbl[6] = '{1'b0, 5'd0,  5'd1,  5'd2, 5'd31, 1'b1, 32'h8000_0081};
        tbl[7] = '{1'b0, 5'd0,  5'd1,  5'd2, 5'd3,  1'b0, 32'h8000_0081};
        for (int i = 0; i < 8; i++) begin
            rsv_valid = tbl[i].rsv_valid; rsv_rd = tbl[i].rsv_rd;
            chk_rs1 = tbl[i].c1; chk_rs2 = tbl[i].c2; chk_rd = tbl[i].c3;
            #1;
            check($sformatf("tbl%0d_hazard", i), hazard, tbl[i].exp_hz);
            tick();
            check($sformatf("tbl%0d_busy", i), busy_mask, tbl[i].exp_busy);
        end

        // Single ALU write: WRITE in cycle 1, ack in cycle 2, IDLE in cycle 3
        do_reset();
        alu_req = 1'b1; alu_rd = 5'd5; alu_length = 3'd4; alu_data = {8{32'h1111_1111}};
        #1;
        check("t1_c0_wbe", write_back_enabled, 0);
        tick();
        check("t1_c1_wbe", write_back_enabled, 1);
        check("t1_c1_signal", rf_signal, `VECTOR_RF_WRITE);
        check("t1_c1_rd", rf_rd, 5);
        check("t1_c1_len", rf_length, 4);
        check("t1_c1_data", rf_data, {8{32'h1111_1111}});
        check("t1_c1_ack", alu_ack, 0);
        rf_status = `RF_FINISHED;
        tick();
        check("t1_c2_ack", {alu_ack, lsu_ack}, 2'b10);
        check("t1_c2_wbe", write_back_enabled, 0);
        tick();
        alu_req = 1'b0;
        #1;
        check("t1_c3_acks", {alu_ack, lsu_ack}, 0);
        tick();
        check("t1_c4_wbe", write_back_enabled, 0);

        // Both requests held from reset
        do_reset();
        alu_req = 1'b1; alu_rd = 5'd1; lsu_req = 1'b1; lsu_rd = 5'd2; rf_status = `RF_FINISHED;
        a_cyc = -1; l_cyc = -1; pa = 1'b0; pl = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (pa) alu_req = 1'b0;
            if (pl) lsu_req = 1'b0;
            #1;
            pa = alu_ack; pl = lsu_ack;
            if (alu_ack && a_cyc < 0) a_cyc = c;
            if (lsu_ack && l_cyc < 0) l_cyc = c;
            tick();
        end
`ifdef VRF_ARB_FIXED_PRIO_EN
        check("t2_lsu_cycle", l_cyc, 2);
        check("t2_alu_cycle", a_cyc, 5);
`else
        check("t2_alu_cycle", a_cyc, 2);
        check("t2_lsu_cycle", l_cyc, 5);
`endif

        // Reservation of v7, then an LSU write to v7 clears it
        do_reset();
        rsv_valid = 1'b1; rsv_rd = 5'd7; chk_rs2 = 5'd7;
        tick();
        rsv_valid = 1'b0;
        #1;
        check("t3_busy_set", busy_mask, 32'h80);
        check("t3_hazard_set", hazard, 1);
        lsu_req = 1'b1; lsu_rd = 5'd7; lsu_length = 3'd2; lsu_data = rand_vec(); rf_status = `RF_FINISHED;
        wait_ack(1'b1, "t3");
        tick();
        lsu_req = 1'b0;
        #1;
        check("t3_busy_clr", busy_mask, 0);
        check("t3_hazard_clr", hazard, 0);

        // Same-cycle reserve and completion of v3: reservation wins
        do_reset();
        alu_req = 1'b1; alu_rd = 5'd3; rf_status = `RF_FINISHED;
        wait_ack(1'b0, "t4");
        rsv_valid = 1'b1; rsv_rd = 5'd3;
        tick();
        rsv_valid = 1'b0; alu_req = 1'b0;
        #1;
        check("t4_busy3", busy_mask, 32'h8);

        // rf_status held at NOP for 4 cycles in WAIT
        do_reset();
        alu_req = 1'b1; alu_rd = 5'd9; rf_status = `RF_NOP;
        tick();
        check("t5_write", write_back_enabled, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("t5_wait%0d_acks", i), {alu_ack, lsu_ack}, 0);
            check($sformatf("t5_wait%0d_wbe", i), write_back_enabled, 0);
        end
        rf_status = `RF_FINISHED;
        #1;
        check("t5_ack", alu_ack, 1);
        tick();
        alu_req = 1'b0;

        // Reset asserted in WRITE abandons the transfer
        do_reset();
        rsv_valid = 1'b1; rsv_rd = 5'd9;
        tick();
        rsv_valid = 1'b0; alu_req = 1'b1; alu_rd = 5'd4;
        tick();
        check("t6_in_write", write_back_enabled, 1);
        rst = 1'b1; rf_status = `RF_FINISHED;
        tick();
        rst = 1'b0; alu_req = 1'b0;
        #1;
        check("t6_wbe", write_back_enabled, 0);
        check("t6_busy", busy_mask, 0);
        check("t6_rd", rf_rd, 0);
        check("t6_acks", {alu_ack, lsu_ack}, 0);
        tick();
        tick();
        check("t6_no_restart", {write_back_enabled, alu_ack, lsu_ack}, 0);

        // rdy_in low for 3 cycles with a pending request
        rdy_in = 1'b0; alu_req = 1'b1; alu_rd = 5'd6; rf_status = `RF_FINISHED;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t6_frozen%0d", i), {write_back_enabled, alu_ack, lsu_ack}, 0);
        end
        rdy_in = 1'b1;
        tick();
        check("t6_grant_wbe", write_back_enabled, 1);
        check("t6_grant_rd", rf_rd, 6);
        wait_ack(1'b0, "t6");
        tick();
        alu_req = 1'b0;

        // Randomized traffic against the model
        do_reset();
        model_reset();
        apend = 1'b0; lpend = 1'b0; ea_prev = 1'b0; el_prev = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (ea_prev) apend = 1'b0;
            if (el_prev) lpend = 1'b0;
            if (!apend) begin
                if ($urandom_range(0, 2) == 0) begin
                    apend = 1'b1; alu_req = 1'b1; alu_rd = 5'($urandom);
                    alu_length = 3'($urandom); alu_data = rand_vec();
                end else alu_req = 1'b0;
            end
            if (!lpend) begin
                if ($urandom_range(0, 2) == 0) begin
                    lpend = 1'b1; lsu_req = 1'b1; lsu_rd = 5'($urandom);
                    lsu_length = 3'($urandom); lsu_data = rand_vec();
                end else lsu_req = 1'b0;
            end
            rsv_valid = ($urandom_range(0, 3) == 0); rsv_rd = 5'($urandom);
            chk_rs1 = 5'($urandom); chk_rs2 = 5'($urandom); chk_rd = 5'($urandom);
            rdy_in = ($urandom_range(0, 9) != 0);
            rf_status = ($urandom_range(0, 1) == 1) ? `RF_FINISHED : `RF_NOP;
            rst = ($urandom_range(0, 149) == 0);
            #1;
            exp_ack = m_active && m_age >= 2 && rf_status == `RF_FINISHED && rdy_in && !rst;
            exp_wbe = m_active && m_age == 1;
            for (int i = 0; i < 32; i++) exp_mask[i] = m_busy[i];
            exp_hz = m_busy[chk_rs1] | m_busy[chk_rs2] | m_busy[chk_rd];
            check("rnd_alu_ack", alu_ack, exp_ack && !m_owner_lsu);
            check("rnd_lsu_ack", lsu_ack, exp_ack && m_owner_lsu);
            check("rnd_wbe", write_back_enabled, exp_wbe);
            check("rnd_signal", rf_signal, exp_wbe ? `VECTOR_RF_WRITE : `VECTOR_RF_NOP);
            check("rnd_rd", rf_rd, m_rd);
            check("rnd_len", rf_length, m_len);
            check("rnd_data", rf_data, m_data);
            check("rnd_busy", busy_mask, exp_mask);
            check("rnd_hazard", hazard, exp_hz);
            ea_prev = exp_ack && !m_owner_lsu;
            el_prev = exp_ack && m_owner_lsu;
            if (rst) begin
                model_reset();
            end else if (rdy_in) begin
                if (exp_ack) begin
                    m_busy[m_rd] = 1'b0;
                    m_last_lsu = m_owner_lsu;
                    m_active = 1'b0;
                end else if (m_active) begin
                    m_age = 2;
                end else if (alu_req || lsu_req) begin
`ifdef VRF_ARB_FIXED_PRIO_EN
                    win_lsu = lsu_req;
`else
                    win_lsu = (alu_req && lsu_req) ? !m_last_lsu : lsu_req;
`endif
                    m_owner_lsu = win_lsu;
                    m_rd   = win_lsu ? lsu_rd : alu_rd;
                    m_len  = win_lsu ? lsu_length : alu_length;
                    m_data = win_lsu ? lsu_data : alu_data;
                    m_active = 1'b1;
                    m_age = 1;
                end
                if (rsv_valid) m_busy[rsv_rd] = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
